// File: rtl/databus_write_arbiter.sv
// rtl/databus_write_arbiter.sv - round-robin, burst-locked arbiter sharing one databus write port
// Bus ownership is held from grant until a valid&ready&last beat; the finished owner drops to lowest priority.
module databus_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int LEN_W      = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  output logic [NUM_REQ-1:0]                  req_last_o,
  input  logic [NUM_REQ*AXI_ADDR_W-1:0]       req_addr_i,
  input  logic [NUM_REQ*AXI_DATA_W-1:0]       req_wdata_i,
  input  logic [NUM_REQ*(AXI_DATA_W/8)-1:0]   req_wstrb_i,
  input  logic [NUM_REQ*LEN_W-1:0]            req_len_i,
  output logic                                databus_valid,
  input  logic                                databus_ready,
  output logic [AXI_ADDR_W-1:0]               databus_addr,
  output logic [AXI_DATA_W-1:0]               databus_wdata,
  output logic [AXI_DATA_W/8-1:0]             databus_wstrb,
  output logic [LEN_W-1:0]                    databus_len,
  input  logic                                databus_last,
  output logic [NUM_REQ-1:0]                  grant_o,
  output logic                                busy_o
);

  localparam int STRB_W = AXI_DATA_W / 8;
  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   last_q, last_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;

  logic [PTR_W-1:0]   winner;
  logic               any_req;
  logic               locked;
  logic               owner_valid;
  logic               beat_done;

  logic [AXI_ADDR_W-1:0] sel_addr;
  logic [AXI_DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0]     sel_wstrb;
  logic [LEN_W-1:0]      sel_len;

  // Scan from last_q+1 upward; iterating downward lets the nearest candidate overwrite the rest.
  always_comb begin
    int idx;
    logic [PTR_W-1:0] idx_p;
    idx     = 0;
    idx_p   = '0;
    winner  = '0;
    any_req = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx   = (int'(last_q) + k) % NUM_REQ;
      idx_p = PTR_W'(idx);
      if (req_valid_i[idx_p]) begin
        winner  = idx_p;
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    sel_addr    = '0;
    sel_wdata   = '0;
    sel_wstrb   = '0;
    sel_len     = '0;
    owner_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == PTR_W'(i)) begin
        sel_addr    = req_addr_i[i*AXI_ADDR_W +: AXI_ADDR_W];
        sel_wdata   = req_wdata_i[i*AXI_DATA_W +: AXI_DATA_W];
        sel_wstrb   = req_wstrb_i[i*STRB_W +: STRB_W];
        sel_len     = req_len_i[i*LEN_W +: LEN_W];
        owner_valid = req_valid_i[i];
      end
    end
  end

  // Every output is gated by the LOCKED state so reset clears them without waiting for a clock.
  assign locked        = (state_q == LOCKED);
  assign databus_valid = locked & owner_valid;
  assign databus_addr  = locked ? sel_addr  : '0;
  assign databus_wdata = locked ? sel_wdata : '0;
  assign databus_wstrb = locked ? sel_wstrb : '0;
  assign databus_len   = locked ? sel_len   : '0;
  assign req_ready_o   = (locked && databus_ready) ? grant_q : '0;
  assign req_last_o    = (locked && databus_last)  ? grant_q : '0;
  assign beat_done     = databus_valid & databus_ready & databus_last;
  assign grant_o       = grant_q;
  assign busy_o        = locked;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = LOCKED;
          owner_d = winner;
          grant_d = NUM_REQ'(1) << winner;
        end
      end
      LOCKED: begin
        if (beat_done) begin
          state_d = IDLE;
          last_d  = owner_q;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= PTR_W'(NUM_REQ - 1);
      owner_q <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
    end
  end

endmodule

// File: tb/tb_databus_write_arbiter.sv
// tb/tb_databus_write_arbiter.sv - self-checking bench for databus_write_arbiter
// Directed scenarios against fixed expectations plus a randomized run against an owner/pointer model.
module tb_databus_write_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int LW = 8;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [N-1:0]      req_valid_i = '0;
  logic [N-1:0]      req_ready_o;
  logic [N-1:0]      req_last_o;
  logic [N*AW-1:0]   req_addr_i = '0;
  logic [N*DW-1:0]   req_wdata_i = '0;
  logic [N*SW-1:0]   req_wstrb_i = '0;
  logic [N*LW-1:0]   req_len_i = '0;
  logic              databus_valid;
  logic              databus_ready = 1'b0;
  logic [AW-1:0]     databus_addr;
  logic [DW-1:0]     databus_wdata;
  logic [SW-1:0]     databus_wstrb;
  logic [LW-1:0]     databus_len;
  logic              databus_last = 1'b0;
  logic [N-1:0]      grant_o;
  logic              busy_o;

  int checks = 0;
  int errors = 0;

  databus_write_arbiter #(
    .NUM_REQ(N), .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .LEN_W(LW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_last_o(req_last_o),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
    .req_len_i(req_len_i),
    .databus_valid(databus_valid), .databus_ready(databus_ready),
    .databus_addr(databus_addr), .databus_wdata(databus_wdata),
    .databus_wstrb(databus_wstrb), .databus_len(databus_len),
    .databus_last(databus_last), .grant_o(grant_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic edge1();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i         = 1'b1;
    req_valid_i   = '0;
    req_addr_i    = '0;
    req_wdata_i   = '0;
    req_wstrb_i   = '0;
    req_len_i     = '0;
    databus_ready = 1'b0;
    databus_last  = 1'b0;
    edge1();
    edge1();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    req_valid_i = 4'hF;
    databus_ready = 1'b1;
    databus_last = 1'b1;
    req_addr_i = {N{32'hDEAD_BEEF}};
    #3;
    checks++; if (grant_o !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b exp 0000", grant_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    checks++; if (databus_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", databus_valid); end
    checks++; if (databus_addr !== '0) begin errors++; $display("FAIL reset_addr got %h exp 0", databus_addr); end
    checks++; if (req_ready_o !== '0 || req_last_o !== '0) begin errors++; $display("FAIL reset_req_out ready %b last %b exp 0", req_ready_o, req_last_o); end
    do_reset();
  endtask

  task automatic test_single_burst();
    logic [DW-1:0] d;
    do_reset();
    req_addr_i[0 +: AW] = 32'h100;
    req_len_i[0 +: LW]  = 8'd3;
    req_wstrb_i[0 +: SW] = 4'hF;
    req_valid_i = 4'b0001;
    databus_ready = 1'b1;
    #1;
    checks++; if (grant_o !== 4'b0000) begin errors++; $display("FAIL t1_latency grant %b exp 0000", grant_o); end
    edge1();
    checks++; if (grant_o !== 4'b0001) begin errors++; $display("FAIL t1_grant got %b exp 0001", grant_o); end
    for (int b = 0; b < 4; b++) begin
      d = $urandom;
      req_wdata_i[0 +: DW] = d;
      databus_last = (b == 3);
      #1;
      checks++; if (databus_valid !== 1'b1 || databus_addr !== 32'h100 || databus_len !== 8'd3 || databus_wdata !== d)
        begin errors++; $display("FAIL t1_beat%0d valid %b addr %h len %0d wdata %h exp 1 100 3 %h", b, databus_valid, databus_addr, databus_len, databus_wdata, d); end
      checks++; if (req_last_o !== ((b == 3) ? 4'b0001 : 4'b0000) || req_ready_o !== 4'b0001)
        begin errors++; $display("FAIL t1_req_out%0d last %b ready %b", b, req_last_o, req_ready_o); end
      edge1();
    end
    req_valid_i = '0;
    databus_last = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0 || grant_o !== 4'b0000) begin errors++; $display("FAIL t1_release busy %b grant %b exp 0 0000", busy_o, grant_o); end
  endtask

  task automatic test_round_robin();
    do_reset();
    req_valid_i = 4'b0111;
    databus_ready = 1'b1;
    databus_last = 1'b1;
    edge1();
    for (int i = 0; i < 3; i++) begin
      checks++; if (grant_o !== (4'b0001 << i) || databus_valid !== 1'b1)
        begin errors++; $display("FAIL t2_grant%0d got %b valid %b exp %b 1", i, grant_o, databus_valid, 4'b0001 << i); end
      edge1();
      req_valid_i[i] = 1'b0;
      if (i == 2) req_valid_i[0] = 1'b1;
      #1;
      checks++; if (grant_o !== 4'b0000 || databus_valid !== 1'b0)
        begin errors++; $display("FAIL t2_bubble%0d grant %b valid %b exp 0000 0", i, grant_o, databus_valid); end
      edge1();
    end
    checks++; if (grant_o !== 4'b0001) begin errors++; $display("FAIL t2_reraise got %b exp 0001", grant_o); end
  endtask

  task automatic test_lock();
    do_reset();
    req_valid_i = 4'b0010;
    databus_ready = 1'b1;
    edge1();
    checks++; if (grant_o !== 4'b0010) begin errors++; $display("FAIL t3_grant got %b exp 0010", grant_o); end
    req_valid_i = 4'b0110;
    edge1();
    req_valid_i = 4'b0100;
    databus_last = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (grant_o !== 4'b0010 || databus_valid !== 1'b0 || busy_o !== 1'b1)
        begin errors++; $display("FAIL t3_gap%0d grant %b valid %b busy %b exp 0010 0 1", c, grant_o, databus_valid, busy_o); end
      edge1();
    end
    req_valid_i = 4'b0110;
    #1;
    checks++; if (grant_o !== 4'b0010 || databus_valid !== 1'b1 || req_last_o !== 4'b0010)
      begin errors++; $display("FAIL t3_last grant %b valid %b last %b exp 0010 1 0010", grant_o, databus_valid, req_last_o); end
    edge1();
    req_valid_i = 4'b0100;
    databus_last = 1'b0;
    #1;
    checks++; if (grant_o !== 4'b0000) begin errors++; $display("FAIL t3_bubble got %b exp 0000", grant_o); end
    edge1();
    checks++; if (grant_o !== 4'b0100) begin errors++; $display("FAIL t3_next got %b exp 0100", grant_o); end
  endtask

  task automatic test_stall();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int beats;
    int cyc;
    do_reset();
    a = $urandom;
    d = $urandom;
    req_addr_i[0 +: AW] = a;
    req_wdata_i[0 +: DW] = d;
    req_len_i[0 +: LW] = 8'd5;
    req_valid_i = 4'b0001;
    databus_ready = 1'b1;
    edge1();
    beats = 0;
    cyc = 0;
    while (busy_o && cyc < 30) begin
      databus_ready = !(cyc >= 2 && cyc <= 4);
      databus_last  = databus_ready && (beats == 5);
      #1;
      checks++; if (databus_addr !== a || databus_wdata !== d || databus_len !== 8'd5 || databus_valid !== 1'b1)
        begin errors++; $display("FAIL t4_hold%0d addr %h wdata %h len %0d valid %b", cyc, databus_addr, databus_wdata, databus_len, databus_valid); end
      checks++; if (req_ready_o !== (databus_ready ? 4'b0001 : 4'b0000))
        begin errors++; $display("FAIL t4_ready%0d got %b exp %b", cyc, req_ready_o, databus_ready ? 4'b0001 : 4'b0000); end
      if (databus_ready) beats++;
      cyc++;
      edge1();
    end
    databus_last = 1'b0;
    checks++; if (beats !== 6 || busy_o !== 1'b0) begin errors++; $display("FAIL t4_beats got %0d busy %b exp 6 0", beats, busy_o); end
  endtask

  task automatic test_async_reset();
    do_reset();
    req_valid_i = 4'b0001;
    databus_ready = 1'b1;
    edge1();
    edge1();
    #2;
    rst_i = 1'b1;
    #1;
    checks++; if (databus_valid !== 1'b0 || grant_o !== 4'b0000 || busy_o !== 1'b0)
      begin errors++; $display("FAIL t5_async valid %b grant %b busy %b exp 0", databus_valid, grant_o, busy_o); end
    req_valid_i = 4'b1001;
    edge1();
    rst_i = 1'b0;
    #1;
    checks++; if (grant_o !== 4'b0000) begin errors++; $display("FAIL t5_idle got %b exp 0000", grant_o); end
    edge1();
    checks++; if (grant_o !== 4'b0001) begin errors++; $display("FAIL t5_regrant got %b exp 0001", grant_o); end
  endtask

  task automatic test_back_to_back();
    int seq [6] = '{0, 3, 0, 3, 0, 3};
    do_reset();
    req_valid_i = 4'b1001;
    databus_ready = 1'b1;
    databus_last = 1'b1;
    for (int i = 0; i < 6; i++) begin
      edge1();
      checks++; if (grant_o !== (4'b0001 << seq[i]))
        begin errors++; $display("FAIL t6_grant%0d got %b exp %b", i, grant_o, 4'b0001 << seq[i]); end
      edge1();
      checks++; if (grant_o !== 4'b0000) begin errors++; $display("FAIL t6_bubble%0d got %b exp 0000", i, grant_o); end
    end
  endtask

  task automatic test_random();
    int owner;
    int ptr;
    int c;
    logic [N-1:0]  e_grant;
    logic          e_valid;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [SW-1:0] e_wstrb;
    logic [LW-1:0] e_len;
    do_reset();
    owner = -1;
    ptr = N - 1;
    for (int cyc = 0; cyc < 500; cyc++) begin
      req_valid_i = N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_addr_i[i*AW +: AW]  = $urandom;
        req_wdata_i[i*DW +: DW] = $urandom;
        req_wstrb_i[i*SW +: SW] = SW'($urandom);
        req_len_i[i*LW +: LW]   = LW'($urandom);
      end
      databus_ready = ($urandom_range(0, 3) != 0);
      databus_last  = ($urandom_range(0, 2) == 0);
      e_grant = '0; e_valid = 1'b0; e_addr = '0; e_wdata = '0; e_wstrb = '0; e_len = '0;
      if (owner >= 0) begin
        e_grant[owner] = 1'b1;
        e_valid = req_valid_i[owner];
        e_addr  = req_addr_i[owner*AW +: AW];
        e_wdata = req_wdata_i[owner*DW +: DW];
        e_wstrb = req_wstrb_i[owner*SW +: SW];
        e_len   = req_len_i[owner*LW +: LW];
      end
      #1;
      checks++; if (grant_o !== e_grant || busy_o !== (owner >= 0) || databus_valid !== e_valid)
        begin errors++; $display("FAIL rnd_ctl%0d grant %b busy %b valid %b exp %b %b %b", cyc, grant_o, busy_o, databus_valid, e_grant, owner >= 0, e_valid); end
      checks++; if (databus_addr !== e_addr || databus_wdata !== e_wdata || databus_wstrb !== e_wstrb || databus_len !== e_len)
        begin errors++; $display("FAIL rnd_data%0d addr %h wdata %h strb %h len %h exp %h %h %h %h", cyc, databus_addr, databus_wdata, databus_wstrb, databus_len, e_addr, e_wdata, e_wstrb, e_len); end
      checks++; if (req_ready_o !== (databus_ready ? e_grant : '0) || req_last_o !== (databus_last ? e_grant : '0))
        begin errors++; $display("FAIL rnd_req%0d ready %b last %b exp %b %b", cyc, req_ready_o, req_last_o, databus_ready ? e_grant : '0, databus_last ? e_grant : '0); end
      if (owner < 0) begin
        for (int k = 1; k <= N; k++) begin
          c = (ptr + k) % N;
          if (owner < 0 && req_valid_i[c]) owner = c;
        end
      end else if (req_valid_i[owner] && databus_ready && databus_last) begin
        ptr = owner;
        owner = -1;
      end
      edge1();
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_lock();
    test_stall();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
